// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DATA_BITS_DEF  = 8;

  // Tick index at which the start bit is re-checked (middle of the bit).
  function automatic int unsigned mid_tick(input int unsigned oversample);
    return oversample / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every (div_q+1) clocks.
module uart_baud_tick #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             load_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;

  // >= rather than == so a divisor shrunk below the running count still wraps.
  assign tick_o = (cnt_q >= div_q);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      if (load_i) div_q <= div_i;
      if (tick_o) cnt_q <= '0;
      else        cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronizer, start qualify, mid-bit sampling, valid/ready delivery.
// Optional even-parity stage enabled by defining UART_RX_PARITY_EN.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
  parameter int unsigned DIV_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [DIV_W-1:0] baud_div_i,
  input  logic             rx_i,
  output logic [7:0]       data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             frame_err_o,
  output logic             parity_err_o,
  output logic             overrun_o,
  input  logic             clr_ovr_i,
  output logic             busy_o
);

  localparam int unsigned     OS_W     = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_MID   = OS_W'(mid_tick(OVERSAMPLE));
  localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [2:0]      BIT_LAST = 3'(DATA_BITS - 1);

  rx_state_e       state_q, state_d;
  logic [OS_W-1:0] os_q, os_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            rx_meta_q, rx_s;
  logic            tick;
  logic            deliver;
  logic            ferr;
`ifdef UART_RX_PARITY_EN
  logic            par_bad_q, par_bad_d;
  logic            perr;
`endif

  assign busy_o = (state_q != IDLE);

  uart_baud_tick #(
    .DIV_W(DIV_W)
  ) u_tick (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .div_i  (baud_div_i),
    .load_i (state_q == IDLE),
    .tick_o (tick)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
      state_q   <= IDLE;
      os_q      <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx_i;
      rx_s      <= rx_meta_q;
      state_q   <= state_d;
      os_q      <= os_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    os_d    = os_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    deliver = 1'b0;
    ferr    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (tick && !rx_s) begin
          state_d = START;
          os_d    = '0;
        end
      end
      START: begin
        if (tick) begin
          if (os_q == OS_MID) begin
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              os_d    = '0;
              bit_d   = '0;
              shift_d = '0;
`ifdef UART_RX_PARITY_EN
              par_bad_d = 1'b0;
`endif
            end
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (os_q == OS_LAST) begin
            shift_d[bit_q] = rx_s;
            os_d           = '0;
            if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (os_q == OS_LAST) begin
            os_d    = '0;
            state_d = STOP;
            // Unused high bits of shift_q are zero, so a full reduction is safe.
            if ((^shift_q) ^ rx_s) begin
              perr      = 1'b1;
              par_bad_d = 1'b1;
            end
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (os_q == OS_LAST) begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (!par_bad_q) begin
              if (rx_s) deliver = 1'b1;
              else      ferr    = 1'b1;
            end
`else
            if (rx_s) deliver = 1'b1;
            else      ferr    = 1'b1;
`endif
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_o      <= '0;
      valid_o     <= 1'b0;
      overrun_o   <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= ferr;
      if (deliver && (!valid_o || ready_i)) begin
        data_o  <= shift_q;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
      if (deliver && valid_o && !ready_i) overrun_o <= 1'b1;
      else if (clr_ovr_i)                 overrun_o <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) parity_err_o <= 1'b0;
    else          parity_err_o <= perr;
  end
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
UART receive controller. It oversamples the serial line, detects and qualifies the start bit, and samples each data bit at mid-bit. It shifts the bits into a parallel byte, checks the stop bit, and presents the byte on a valid/ready handshake. It sits between the board RX pin and the game logic. It sequences the serial-to-parallel shifter and owns the baud timing.

Parameters:
OVERSAMPLE, 16, ticks per bit period; power of two, at least 4.
DATA_BITS, 8, data bits per frame; range 5..8.
DIV_W, 16, width of the baud divisor input.

Ports:
clk_i  in  1  system clock.
rst_n_i  in  1  reset, asynchronous, active-low.
baud_div_i  in  DIV_W  clocks per oversample tick, minus 1.
rx_i  in  1  raw serial line; asynchronous; idles high.
data_o  out  8  received byte, LSB = first bit; unused high bits are 0.
valid_o  out  1  data_o holds an unconsumed byte.
ready_i  in  1  consumer accepts the byte when valid_o && ready_i.
frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
parity_err_o  out  1  one-cycle pulse: parity mismatch (see Optional Feature).
overrun_o  out  1  sticky: a byte was dropped because valid_o was still high.
clr_ovr_i  in  1  synchronous clear of overrun_o.
busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset: one clock and rst_n_i (asynchronous, active-low).
  - Outputs: data_o=0, valid_o=0, frame_err_o=0, parity_err_o=0, overrun_o=0, busy_o=0.
  - Internal: synchronizer flops=1, counters=0, state=IDLE.
  - Reset mid-frame aborts the frame with no output.
- rx_i passes through a 2-flop synchronizer. All sampling uses the synced value (rx_s).
- Tick generator:
  - Counter runs 0..div_q and emits a one-clock tick when counter==div_q, then wraps to 0.
  - div_q latches baud_div_i in IDLE only. Changes to baud_div_i mid-frame have no effect on the current frame.
  - baud_div_i=0 gives a tick every clock.
- FSM, advanced on ticks only; os_cnt counts ticks within a bit:
  - IDLE: tick && rx_s==0 -> START, os_cnt=0.
  - START: on the tick where os_cnt==OVERSAMPLE/2-1, sample rx_s. 1 -> IDLE (glitch rejected, no flags). 0 -> DATA, os_cnt=0, bit_cnt=0.
  - DATA: on the tick where os_cnt==OVERSAMPLE-1, sample rx_s into bit position bit_cnt and reset os_cnt.
    - bit_cnt==DATA_BITS-1 -> STOP (or PARITY when enabled).
    - Otherwise bit_cnt++.
  - STOP: on the tick where os_cnt==OVERSAMPLE-1, sample rx_s.
    - 1 -> deliver the byte.
    - 0 -> pulse frame_err_o, discard the byte.
    - Either way -> IDLE. The next start can be detected on the next tick.
- Timing: the stop sample lands OVERSAMPLE/2 + OVERSAMPLE*(DATA_BITS+1) ticks after start detect. valid_o rises on the clock after that sample.
- Delivery handshake:
  - valid_o clears on the clock after valid_o && ready_i.
  - Delivery with valid_o==0: data_o<=byte, valid_o<=1.
  - Delivery with valid_o==1 and ready_i==1 in the same cycle: data_o<=new byte, valid_o stays 1, no overrun.
  - Delivery with valid_o==1 and ready_i==0: new byte dropped, data_o unchanged, overrun_o<=1.
  - data_o is stable while valid_o==1.
- overrun_o:
  - Cleared by clr_ovr_i.
  - clr_ovr_i and a new overrun in the same cycle: set wins.
- Error pulses: frame_err_o and parity_err_o are exactly one clock wide. They are never asserted together for the same frame; parity is checked first.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and takes one bit period, sampled at os_cnt==OVERSAMPLE-1.
  - Parity is even: XOR of the data bits and the parity bit must be 0.
  - On mismatch: pulse parity_err_o, discard the byte, skip the stop check, return to IDLE after the stop-bit period.
  - Frame length becomes DATA_BITS+3 bit periods.
- Undefined: the PARITY state does not exist and parity_err_o is tied 0.

Decomposition:
- Package uart_pkg:
  - State enum rx_state_e {IDLE, START, DATA, PARITY, STOP}.
  - Constants for the default OVERSAMPLE and DATA_BITS.
  - Helper function mid_tick(oversample) returning OVERSAMPLE/2-1.
- Sub-module uart_baud_tick: divisor counter with divisor latch enable, output tick.
- The shift register and FSM stay in uart_rx_ctrl.

Test Plan:
- Nominal byte: baud_div_i=3, OVERSAMPLE=16 (64 clocks/bit), send 0xA5 8N1, ready_i=1.
  -> data_o=0xA5, valid_o high for exactly 1 clock, rising 1 clock after the stop sample (152 ticks after start detect). No error flags.
- Glitch reject: rx_i low for 4 ticks, then high. -> No valid_o, no errors; busy_o high during START only, then 0.
- Framing error: send 0x3C with stop bit 0. -> frame_err_o pulses 1 clock, valid_o stays 0. The next good frame 0x55 is received correctly.
- Overrun: two frames 0x11 then 0x22 back-to-back, ready_i=0. -> data_o=0x11, overrun_o=1.
  - Then ready_i=1 -> valid_o clears.
  - Then clr_ovr_i=1 for 1 clock -> overrun_o=0.
- Same-cycle accept plus delivery: hold valid_o with 0x11, assert ready_i exactly on the 0x22 delivery clock.
  -> data_o=0x22, valid_o stays 1, overrun_o=0.
- Reset mid-frame: drop rst_n_i at bit 4 of a frame. -> All outputs 0 immediately. After release, the following frame 0x7E is received correctly.
- With UART_RX_PARITY_EN defined: send 0x07 with parity bit 0 (odd total). -> parity_err_o pulses, no valid_o.
